// File: rtl/accel_pkg.sv
// Shared accelerator definitions: refill FSM encoding and GBF channel indices.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam int unsigned ACTV1      = 0;
  localparam int unsigned ACTV2      = 1;
  localparam int unsigned WGT1       = 2;
  localparam int unsigned WGT2       = 3;
  localparam int unsigned NUM_GBF_CH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last advanced grant.
module rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] prio_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after the priority pointer, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((32'(prio_q) + k) % NUM_CH);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= '0;
    end else if (advance && found) begin
      prio_q <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/gbf_refill_ctrl.sv
// GBF refill controller: latches per-channel empty edges, arbitrates in IDLE,
// requests a burst from memory and streams GBF_DEPTH beats into the chosen GBF.
module gbf_refill_ctrl
  import accel_pkg::*;
#(
  parameter  int unsigned NUM_CH            = 4,
  parameter  int unsigned GBF_DATA_BITWIDTH = 256,
  parameter  int unsigned GBF_ADDR_BITWIDTH = 5,
  parameter  int unsigned GBF_DEPTH         = 32,
  localparam int unsigned CH_W              = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            need_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [CH_W-1:0]              mem_req_ch,
  input  logic                         mem_rsp_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] mem_rsp_data,
  output logic                         mem_rsp_ready,
  output logic [NUM_CH-1:0]            gbf_w_en,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_w_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
  output logic [NUM_CH-1:0]            fill_done,
  output logic                         busy
);

  localparam logic [GBF_ADDR_BITWIDTH-1:0] LAST_BEAT = GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1);

  refill_state_e                state_q, state_d;
  logic [CH_W-1:0]              cur_ch_q, cur_ch_d;
  logic [GBF_ADDR_BITWIDTH-1:0] beat_q, beat_d;
  logic [NUM_CH-1:0]            pending_q, pending_d;
  logic [NUM_CH-1:0]            need_prev_q;
  logic [NUM_CH-1:0]            ch_oh;
  logic [NUM_CH-1:0]            grant;
  logic [CH_W-1:0]              grant_idx;
  logic                         arb_adv;

  assign ch_oh      = NUM_CH'(1) << cur_ch_q;
  assign mem_req_ch = cur_ch_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (pending_q),
    .advance   (arb_adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // need_prev clears on reset so a level already high counts as a fresh edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_ch_q    <= '0;
      beat_q      <= '0;
      pending_q   <= '0;
      need_prev_q <= '0;
    end else begin
      cur_ch_q    <= cur_ch_d;
      beat_q      <= beat_d;
      pending_q   <= pending_d;
      need_prev_q <= need_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    beat_d        = beat_q;
    arb_adv       = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    gbf_w_en      = '0;
    gbf_w_addr    = '0;
    gbf_w_data    = '0;
    fill_done     = '0;
    busy          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          arb_adv  = 1'b1;
          cur_ch_d = grant_idx;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        busy          = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        busy          = 1'b1;
        mem_rsp_ready = 1'b1;
        // Beats are written straight through in the cycle they are accepted
        if (mem_rsp_valid) begin
          gbf_w_en   = ch_oh;
          gbf_w_addr = beat_q;
          gbf_w_data = mem_rsp_data;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + GBF_ADDR_BITWIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        fill_done = ch_oh;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Edges on the channel currently being served are dropped
    pending_d = (pending_q & ~fill_done)
              | (need_data & ~need_prev_q & ~(busy ? ch_oh : NUM_CH'(0)));
  end

endmodule

// File: tb/tb_gbf_refill_ctrl.sv
// Bench for gbf_refill_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a procedural reference model of the refill protocol.
module tb_gbf_refill_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW     = 256;
  localparam int unsigned AW     = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] need_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [1:0]        mem_req_ch;
  logic              mem_rsp_valid;
  logic [DW-1:0]     mem_rsp_data;
  logic              mem_rsp_ready;
  logic [NUM_CH-1:0] gbf_w_en;
  logic [AW-1:0]     gbf_w_addr;
  logic [DW-1:0]     gbf_w_data;
  logic [NUM_CH-1:0] fill_done;
  logic              busy;

  always #5 clk = ~clk;

  gbf_refill_ctrl #(
    .NUM_CH            (NUM_CH),
    .GBF_DATA_BITWIDTH (DW),
    .GBF_ADDR_BITWIDTH (AW),
    .GBF_DEPTH         (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .need_data     (need_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_ch    (mem_req_ch),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_ready (mem_rsp_ready),
    .gbf_w_en      (gbf_w_en),
    .gbf_w_addr    (gbf_w_addr),
    .gbf_w_data    (gbf_w_data),
    .fill_done     (fill_done),
    .busy          (busy)
  );

  int n_checks;
  int n_errors;
  int cyc;

  // Reference model: phase 0 idle, 1 requesting, 2 streaming beats, 3 done pulse
  int          m_ph;
  int          m_ch;
  int          m_beat;
  int          m_ptr;
  logic [3:0]  m_pend;
  logic [3:0]  m_prev;
  bit          m_just_rst;

  int wr_cnt;
  int done_ch_q[$];
  int done_cyc_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0] oh;
    logic [3:0] rise;
    logic [3:0] mask;
    bit         wr;
    bit         found;
    oh = 4'b0001 << m_ch;
    wr = (m_ph == 2) && mem_rsp_valid;

    chk("busy", busy, m_ph != 0);
    chk("req_valid", mem_req_valid, m_ph == 1);
    if (m_ph == 1) chk("req_ch", mem_req_ch, m_ch);
    chk("rsp_ready", mem_rsp_ready, m_ph == 2);
    chk("w_en", gbf_w_en, wr ? oh : 4'b0000);
    if (wr) begin
      chk("w_addr", gbf_w_addr, m_beat);
      chk("w_data", gbf_w_data, mem_rsp_data);
    end
    chk("fill_done", fill_done, (m_ph == 3) ? oh : 4'b0000);
    if (m_just_rst) begin
      chk("rst_req_ch", mem_req_ch, 0);
      chk("rst_w_addr", gbf_w_addr, 0);
      chk("rst_w_data", gbf_w_data, 0);
    end

    if (gbf_w_en != 0) wr_cnt++;
    for (int b = 0; b < NUM_CH; b++) begin
      if (fill_done[b]) begin
        done_ch_q.push_back(b);
        done_cyc_q.push_back(cyc);
      end
    end

    rise = need_data & ~m_prev;
    mask = (m_ph != 0) ? oh : 4'b0000;
    case (m_ph)
      0: begin
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          int idx;
          idx = (m_ptr + k) % NUM_CH;
          if (!found && m_pend[idx]) begin
            found = 1'b1;
            m_ch  = idx;
            m_ptr = (idx + 1) % NUM_CH;
            m_ph  = 1;
          end
        end
      end
      1: if (mem_req_ready) begin
        m_ph   = 2;
        m_beat = 0;
      end
      2: if (mem_rsp_valid) begin
        if (m_beat == DEPTH - 1) m_ph = 3;
        else m_beat++;
      end
      default: begin
        m_pend[m_ch] = 1'b0;
        m_ph         = 0;
      end
    endcase
    m_pend     = m_pend | (rise & ~mask);
    m_prev     = need_data;
    m_just_rst = 1'b0;
    if (reset) begin
      m_ph       = 0;
      m_ch       = 0;
      m_beat     = 0;
      m_ptr      = 0;
      m_pend     = '0;
      m_prev     = '0;
      m_just_rst = 1'b1;
    end
    cyc++;
  endtask

  task automatic cycle();
    for (int i = 0; i < DW / 32; i++) mem_rsp_data[i*32 +: 32] = $urandom;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    done_ch_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    need_data     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    cycle();
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    int t0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_ph     = 0;
    m_ch     = 0;
    m_beat   = 0;
    m_ptr    = 0;
    m_pend   = '0;
    m_prev   = '0;
    m_just_rst = 1'b0;
    reset         = 1'b1;
    need_data     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    clear_log();
    @(posedge clk);
    #1;

    // Single request: latency, write count and channel
    do_reset();
    idle(2);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    need_data     = 4'b0001;
    t0 = cyc;
    idle(40);
    chk("s1_wr_cnt", wr_cnt, DEPTH);
    chk("s1_done_n", done_ch_q.size(), 1);
    if (done_ch_q.size() > 0) begin
      chk("s1_done_ch", done_ch_q[0], 0);
      chk("s1_latency", done_cyc_q[0] - t0, DEPTH + 3);
    end

    // All four channels at once: served 0..3, back to back
    do_reset();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    need_data     = 4'b1111;
    idle(4 * (DEPTH + 4) + 10);
    chk("s2_done_n", done_ch_q.size(), 4);
    chk("s2_wr_cnt", wr_cnt, 4 * DEPTH);
    for (int i = 0; i < done_ch_q.size() && i < 4; i++) begin
      chk("s2_order", done_ch_q[i], i);
      if (i > 0) chk("s2_spacing", done_cyc_q[i] - done_cyc_q[i-1], DEPTH + 3);
    end

    // Backpressure: request stalled, then every other beat valid
    do_reset();
    need_data = 4'b0001;
    idle(7);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 200 && done_ch_q.size() == 0; i++) begin
      mem_rsp_valid = ~mem_rsp_valid;
      cycle();
    end
    chk("s3_done_n", done_ch_q.size(), 1);
    chk("s3_wr_cnt", wr_cnt, DEPTH);

    // Round robin: after channel 2, channel 3 wins over channel 0
    do_reset();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    need_data     = 4'b0100;
    idle(5);
    need_data = 4'b1101;
    idle(3 * (DEPTH + 4) + 10);
    chk("s4_done_n", done_ch_q.size(), 3);
    if (done_ch_q.size() == 3) begin
      chk("s4_first", done_ch_q[0], 2);
      chk("s4_second", done_ch_q[1], 3);
      chk("s4_third", done_ch_q[2], 0);
    end

    // Reset at beat 10 aborts without fill_done; a new edge restarts at address 0
    do_reset();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    need_data     = 4'b0001;
    for (int i = 0; i < 60 && wr_cnt < 10; i++) cycle();
    chk("s5_reached_beat10", wr_cnt, 10);
    reset     = 1'b1;
    need_data = '0;
    cycle();
    reset = 1'b0;
    clear_log();
    idle(40);
    chk("s5_no_done", done_ch_q.size(), 0);
    chk("s5_no_write", wr_cnt, 0);
    need_data = 4'b0001;
    idle(40);
    chk("s5_refill_n", done_ch_q.size(), 1);
    chk("s5_refill_wr", wr_cnt, DEPTH);

    // Held level triggers exactly one refill
    do_reset();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    need_data     = 4'b0010;
    idle(100);
    chk("s6_done_n", done_ch_q.size(), 1);
    if (done_ch_q.size() > 0) chk("s6_done_ch", done_ch_q[0], 1);
    chk("s6_wr_cnt", wr_cnt, DEPTH);

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NUM_CH; b++) begin
        if ($urandom_range(15) == 0) need_data[b] = ~need_data[b];
      end
      mem_req_ready = ($urandom_range(3) != 0);
      mem_rsp_valid = ($urandom_range(3) != 0);
      reset         = ($urandom_range(399) == 0);
      cycle();
    end
    reset = 1'b0;
    chk("rnd_fills_seen", done_ch_q.size() > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gbf_refill_ctrl.md
GBF_REFILL_CTRL -- requirements
Module: gbf_refill_ctrl

Interface
REQ-001 The module SHALL take parameter NUM_CH, default 4, as the number of GBF channels (actv1, actv2, wgt1, wgt2 order).
REQ-002 The module SHALL take parameter GBF_DATA_BITWIDTH, default 256, as the GBF word width.
REQ-003 The module SHALL take parameter GBF_ADDR_BITWIDTH, default 5, as the GBF address width.
REQ-004 The module SHALL take parameter GBF_DEPTH, default 32, as the words per GBF and per refill burst.
REQ-005 The module SHALL provide the port clk, input, 1 bit, as the single clock.
REQ-006 The module SHALL provide the port reset, input, 1 bit, as a synchronous active-high reset.
REQ-007 The module SHALL provide need_data, input, NUM_CH bits, as per-channel GBF-empty levels.
REQ-008 The module SHALL provide mem_req_valid, output, 1 bit, as the refill request valid.
REQ-009 The module SHALL provide mem_req_ready, input, 1 bit, as the memory accepting the request.
REQ-010 The module SHALL provide mem_req_ch, output, $clog2(NUM_CH) bits, as the channel being refilled.
REQ-011 The module SHALL provide mem_rsp_valid, input, 1 bit, as the data beat valid.
REQ-012 The module SHALL provide mem_rsp_data, input, GBF_DATA_BITWIDTH bits, as the data beat.
REQ-013 The module SHALL provide mem_rsp_ready, output, 1 bit, as the controller accepting the beat.
REQ-014 The module SHALL provide gbf_w_en, output, NUM_CH bits, as the one-hot GBF write enable.
REQ-015 The module SHALL provide gbf_w_addr, output, GBF_ADDR_BITWIDTH bits, as the GBF write address.
REQ-016 The module SHALL provide gbf_w_data, output, GBF_DATA_BITWIDTH bits, as the GBF write data.
REQ-017 The module SHALL provide fill_done, output, NUM_CH bits, as a one-cycle pulse per completed refill.
REQ-018 The module SHALL provide busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-019 Per channel, a pending bit SHALL set on the rising edge of need_data and SHALL clear when that channel's fill_done pulses; a level held high SHALL NOT retrigger.
REQ-020 The FSM SHALL have four states: IDLE, REQ, FILL and DONE.
REQ-021 IDLE->REQ SHALL occur when any pending bit is set; the channel SHALL be selected round-robin, starting after the last served channel (channel 0 first after reset).
REQ-022 In REQ, mem_req_valid SHALL be 1 and mem_req_ch SHALL hold stable; REQ->FILL SHALL occur on the cycle with valid&&ready.
REQ-023 In FILL, mem_rsp_ready SHALL be 1; each accepted beat SHALL drive gbf_w_en[ch]=1, gbf_w_data=beat and gbf_w_addr=beat count in the same cycle (combinational, zero latency).
REQ-024 The beat counter SHALL start at 0 and increment per accepted beat; on beat GBF_DEPTH-1, FILL->DONE.
REQ-025 Gaps in mem_rsp_valid SHALL stall the counter without writing.
REQ-026 DONE SHALL last exactly one cycle, pulse fill_done[ch] and return to IDLE.
REQ-027 A need_data rising edge on the channel being filled SHALL be ignored; pending bits for other channels SHALL still set.
REQ-028 Arbitration SHALL take place only in IDLE, never mid-burst.
REQ-029 Minimum refill latency, from the need_data edge to fill_done, SHALL be GBF_DEPTH+3 cycles with ready and valid held high.

Reset
REQ-030 On reset, the FSM SHALL enter IDLE, and the pending bits, beat counter and round-robin pointer SHALL be cleared.
REQ-031 On reset, all outputs SHALL be 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no fill_done pulse; channels still requesting SHALL need a new rising edge of need_data.
REQ-033 need_data SHALL be treated as previous=0 after reset, so a level already high SHALL register as a rising edge on the first cycle after reset.

Structure
REQ-034 The FSM state encoding and the channel index constants (ACTV1=0, ACTV2=1, WGT1=2, WGT2=3) SHALL be placed in the shared package accel_pkg.
REQ-035 The round-robin arbiter SHALL be a sub-module, rr_arbiter, parameterised by NUM_CH, with inputs req/advance and outputs grant one-hot and grant index.
REQ-036 The target size SHALL be 150-300 lines of RTL.

Verification
REQ-037 The bench SHALL cover a single request: need_data=4'b0001 with ready and valid held high -> mem_req_ch=0, 32 writes with addresses 0..31, fill_done=4'b0001 at cycle 35.
REQ-038 The bench SHALL cover simultaneous requests: need_data=4'b1111 -> served in order 0, 1, 2, 3 with four fill_done pulses and no overlap.
REQ-039 The bench SHALL cover backpressure: mem_req_ready low for 5 cycles, then valid toggling 1/0 -> mem_req_ch stable throughout, exactly 32 writes, addresses contiguous.
REQ-040 The bench SHALL cover round-robin: channel 2 served, then channels 0 and 3 pending -> channel 3 served before channel 0.
REQ-041 The bench SHALL cover reset mid-burst: reset at beat 10 -> all outputs 0 the next cycle, no fill_done; a re-raised need_data triggers a fresh burst starting at address 0.
REQ-042 The bench SHALL cover a held level: need_data[1] high for 100 cycles -> exactly one refill of channel 1.
